led_display_pattern_gen: RTL and testbench
==========================================

LED_DISPLAY_PATTERN_GEN -- requirements
Module: led_display_pattern_gen

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter SIMULATION, default 0, meaning 1 selects the fast row pacing used in simulation.
REQ-003 SHALL have port clk_in, input, 1 bit, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_in, input, 1 bit, reset, asynchronous, active-high.
REQ-005 SHALL have port colour_in, input, 3 bits: bit0 red, bit1 green, bit2 blue.
REQ-006 SHALL have port mode_in, input, 4 bits, pattern select.
REQ-007 SHALL have port row_out, output, 384 bits (rgb_row_t), the row pixel data.
REQ-008 SHALL have port row_valid_out, output, 1 bit, a one-cycle row strobe.
REQ-009 SHALL have port row_ready_in, input, 1 bit, the downstream driver is able to accept a row.
REQ-010 SHALL have port row_address_out, output, 4 bits, the row-pair address (0-15) of the row being presented.
REQ-011 SHALL pack row_out MSB-first as {top.red, top.green, top.blue, bot.red, bot.green, bot.blue}, 64 bits per field.
REQ-012 SHALL map pixel column c (0-63) to bit c of each field.

Function
REQ-013 SHALL define mode encodings as localparams: MODE_OFF=0, MODE_SOLID=1, DEBUG_V=2, DEBUG_H=3.
REQ-014 SHALL treat mode values 4-15 as MODE_OFF.
REQ-015 SHALL register mode_in into mode_q every cycle.
REQ-016 SHALL define mode_change as mode_in != mode_q.
REQ-017 SHALL use row period ROW_PERIOD = 1 cycle when SIMULATION=1, else SYS_CLK_FREQ/1600 cycles (16 rows at 100 Hz frame rate).
REQ-018 SHALL implement the row-period timer as a counter wide enough for ROW_PERIOD, with expiry = count reached ROW_PERIOD-1.
REQ-019 SHALL implement the state machine IDLE -> WAIT_READY -> PRESENT -> IDLE.
REQ-020 SHALL leave IDLE for WAIT_READY when the timer expires.
REQ-021 SHALL leave WAIT_READY for PRESENT when row_ready_in=1 and mode_change=0.
REQ-022 SHALL always leave PRESENT for IDLE after exactly one cycle.
REQ-023 SHALL drive row_valid_out=1 only in PRESENT, so it is never high on 2 consecutive cycles.
REQ-024 SHALL register row_out and row_valid_out, updating row_out on the same edge that enters PRESENT.
REQ-025 SHALL hold row_out stable outside PRESENT.
REQ-026 SHALL increment row_address_out mod 16 on the edge leaving PRESENT (15 wraps to 0).
REQ-027 SHALL keep row_address_out equal to the count of valid strobes since the last mode change or reset, mod 16.
REQ-028 SHALL, on mode_change, on the next edge set row_address_out=0, return the state to IDLE, clear the timer and keep row_valid_out=0.
REQ-029 SHALL give mode_change priority over a simultaneous PRESENT entry.
REQ-030 SHALL generate MODE_OFF data as all 384 bits 0.
REQ-031 SHALL generate MODE_SOLID data with every red bit (top and bot) = colour_in[0], green = colour_in[1], blue = colour_in[2].
REQ-032 SHALL generate DEBUG_V data with column c, when c[2:0]==0, taking the colour_in bits in both halves, and all other columns 0.
REQ-033 SHALL generate DEBUG_H data as full rows in colour_in when row address[2:0]==0, and all 0 otherwise.
REQ-034 SHALL use colour_in as sampled on the PRESENT-entry edge.
REQ-035 SHALL not require row_ready_in to be held through PRESENT, since the transfer occurs on the strobe.

Reset
REQ-036 SHALL, while reset_in=1 (asynchronous), force row_out=0, row_valid_out=0, row_address_out=0, state=IDLE, timer=0 and mode_q=0.
REQ-037 SHALL, after a mid-row reset, restart from address 0 with no partial strobe.

Verification
REQ-038 SHALL verify: SIMULATION=1, MODE_OFF, ready held 1 -> valid strobes with row_out all 0 and address sequence 0,1,..,15,0.
REQ-039 SHALL verify: MODE_SOLID, colour=3'b101 -> each strobe has red and blue fields all 1s and green fields all 0s.
REQ-040 SHALL verify: switch to DEBUG_V with colour 1 at address 7 -> next cycle address=0 and no valid, then strobes with red bits 0,8,..,56 set.
REQ-041 SHALL verify: ready held 0 for 50 cycles -> no valid and address frozen; ready raised -> exactly one strobe per row period.
REQ-042 SHALL verify: reset_in asserted mid-sequence at address 9 -> outputs 0 immediately (before the next edge) and restart at address 0.
REQ-043 SHALL verify: mode_in=4'hF with colour 7 -> row_out all 0 and address still cycling.

Source files
------------

// File: rtl/led_display_pattern_gen.sv
// Row pattern generator for a 64x32 RGB LED panel: paces out 16 row-pairs per frame and
// hands each row to the downstream driver through a ready/strobe handshake.
module led_display_pattern_gen #(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned SIMULATION   = 0
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic [2:0]   colour_in,
  input  logic [3:0]   mode_in,
  output logic [383:0] row_out,
  output logic         row_valid_out,
  input  logic         row_ready_in,
  output logic [3:0]   row_address_out
);

  localparam logic [3:0] MODE_OFF   = 4'd0;
  localparam logic [3:0] MODE_SOLID = 4'd1;
  localparam logic [3:0] DEBUG_V    = 4'd2;
  localparam logic [3:0] DEBUG_H    = 4'd3;

  localparam int unsigned ROW_PERIOD = (SIMULATION != 0) ? 1 : SYS_CLK_FREQ / 1600;
  localparam int unsigned TIMER_W    = (ROW_PERIOD > 1) ? $clog2(ROW_PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROW_PERIOD - 1);

  localparam logic [63:0] DEBUG_V_MASK = 64'h0101_0101_0101_0101;

  typedef enum logic [1:0] {StIdle, StWaitReady, StPresent} state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           mode_q;
  logic [3:0]           addr_q, addr_d;
  logic [383:0]         row_q, row_d;
  logic                 valid_q, valid_d;

  logic                 mode_change;
  logic                 timer_expired;
  logic [63:0]          col_mask;
  logic [63:0]          red_f, green_f, blue_f;
  logic [383:0]         pattern;

  assign mode_change   = (mode_in != mode_q);
  assign timer_expired = (timer_q == TIMER_LAST);

  always_comb begin
    col_mask = '0;
    case (mode_q)
      MODE_OFF:   col_mask = '0;
      MODE_SOLID: col_mask = '1;
      DEBUG_V:    col_mask = DEBUG_V_MASK;
      DEBUG_H:    col_mask = (addr_q[2:0] == 3'd0) ? '1 : '0;
      default:    col_mask = '0;
    endcase
    red_f   = colour_in[0] ? col_mask : '0;
    green_f = colour_in[1] ? col_mask : '0;
    blue_f  = colour_in[2] ? col_mask : '0;
    pattern = {red_f, green_f, blue_f, red_f, green_f, blue_f};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    valid_d = 1'b0;
    // Timer free-runs so each row slot stays one ROW_PERIOD long regardless of FSM latency.
    timer_d = timer_expired ? '0 : timer_q + 1'b1;
    if (mode_change) begin
      state_d = StIdle;
      timer_d = '0;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (timer_expired) state_d = StWaitReady;
        end
        StWaitReady: begin
          if (row_ready_in) begin
            state_d = StPresent;
            valid_d = 1'b1;
            row_d   = pattern;
          end
        end
        StPresent: begin
          state_d = StIdle;
          addr_d  = addr_q + 4'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= StIdle;
      timer_q <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mode_q  <= mode_in;
      addr_q  <= addr_d;
      row_q   <= row_d;
      valid_q <= valid_d;
    end
  end

  assign row_out         = row_q;
  assign row_valid_out   = valid_q;
  assign row_address_out = addr_q;

endmodule

// File: tb/tb_led_display_pattern_gen.sv
// Randomised bench for led_display_pattern_gen: a per-column pixel model predicts every strobe,
// and the strobe counter since the last mode change/reset predicts the row address.
module tb_led_display_pattern_gen;

  logic         clk;
  logic         rst;
  logic [2:0]   colour;
  logic [3:0]   mode;
  logic         ready;
  logic [383:0] row;
  logic         valid;
  logic [3:0]   addr;

  int checks = 0;
  int errors = 0;

  // Model state: mode seen at the previous edge, strobes since last restart, previous valid.
  logic [3:0] mq;
  int         cnt;
  logic       last_valid;
  int         strobes;

  led_display_pattern_gen #(
    .SYS_CLK_FREQ(100_000_000),
    .SIMULATION  (1)
  ) dut (
    .clk_in         (clk),
    .reset_in       (rst),
    .colour_in      (colour),
    .mode_in        (mode),
    .row_out        (row),
    .row_valid_out  (valid),
    .row_ready_in   (ready),
    .row_address_out(addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel-by-pixel picture of what each pattern should look like.
  function automatic logic [383:0] exp_row(input logic [3:0] m, input logic [2:0] c, input int a);
    logic [63:0] f [3];
    logic        on;
    for (int k = 0; k < 3; k++) f[k] = '0;
    for (int col = 0; col < 64; col++) begin
      on = (m == 4'd1) || (m == 4'd2 && col % 8 == 0) || (m == 4'd3 && a % 8 == 0);
      for (int k = 0; k < 3; k++) f[k][col] = on & c[k];
    end
    return {f[0], f[1], f[2], f[0], f[1], f[2]};
  endfunction

  // Drive inputs for the next rising edge, then judge the outputs that edge produced.
  task automatic step(input logic [2:0] c, input logic [3:0] m, input logic r);
    colour = c;
    mode   = m;
    ready  = r;
    @(negedge clk);
    if (m != mq) begin
      check_eq("mode_change_valid", {383'd0, valid}, '0);
      check_eq("mode_change_addr", {380'd0, addr}, '0);
      cnt = 0;
    end else begin
      check_eq("addr_track", {380'd0, addr}, 384'(cnt % 16));
      if (valid) begin
        check_eq("valid_needs_ready", {383'd0, r}, 384'd1);
        check_eq("valid_not_back_to_back", {383'd0, last_valid}, '0);
        check_eq("row_data", row, exp_row(m, c, cnt % 16));
        cnt++;
        strobes++;
      end
    end
    last_valid = valid;
    mq         = m;
  endtask

  task automatic run(input int n, input logic [2:0] c, input logic [3:0] m, input logic r);
    for (int i = 0; i < n; i++) step(c, m, r);
  endtask

  task automatic run_to_addr(input logic [3:0] target, input logic [2:0] c, input logic [3:0] m);
    int guard;
    guard = 0;
    while (addr != target && guard < 200) begin
      step(c, m, 1'b1);
      guard++;
    end
    check_eq("reach_addr", {380'd0, addr}, {380'd0, target});
  endtask

  initial begin
    rst = 1'b1; colour = '0; mode = '0; ready = 1'b0;
    mq = '0; cnt = 0; last_valid = 1'b0; strobes = 0;
    #1;
    check_eq("reset_row", row, '0);
    check_eq("reset_valid", {383'd0, valid}, '0);
    check_eq("reset_addr", {380'd0, addr}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Blank frames: address must walk 0..15 and wrap.
    strobes = 0;
    run(60, 3'b111, 4'd0, 1'b1);
    check_eq("off_progress", {383'd0, strobes >= 17}, 384'd1);

    strobes = 0;
    run(40, 3'b101, 4'd1, 1'b1);
    check_eq("solid_progress", {383'd0, strobes >= 8}, 384'd1);

    run_to_addr(4'd7, 3'b101, 4'd1);
    run(40, 3'b001, 4'd2, 1'b1);

    for (int i = 0; i < 60; i++) step(3'($urandom_range(0, 7)), 4'd3, 1'b1);

    // Stalled driver: nothing may be presented, address frozen.
    strobes = 0;
    run(50, 3'b011, 4'd3, 1'b0);
    check_eq("stall_no_strobe", 384'(strobes), '0);
    strobes = 0;
    run(48, 3'b011, 4'd3, 1'b1);
    check_eq("unstall_progress", {383'd0, strobes >= 10}, 384'd1);

    strobes = 0;
    run(50, 3'b111, 4'hF, 1'b1);
    check_eq("illegal_mode_cycles", {383'd0, strobes >= 10}, 384'd1);

    for (int i = 0; i < 500; i++) begin
      logic [3:0] m;
      m = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : mq;
      step(3'($urandom_range(0, 7)), m, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-sequence at address 9.
    run_to_addr(4'd9, 3'b111, 4'd1);
    rst = 1'b1;
    #1;
    check_eq("midreset_row", row, '0);
    check_eq("midreset_valid", {383'd0, valid}, '0);
    check_eq("midreset_addr", {380'd0, addr}, '0);
    @(negedge clk);
    rst = 1'b0;
    mq = '0; cnt = 0; last_valid = 1'b0;
    strobes = 0;
    run(40, 3'b110, 4'd1, 1'b1);
    check_eq("post_reset_progress", {383'd0, strobes >= 8}, 384'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
